mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
Parameters: none.

REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 req  input  1  pipeline access request, sampled only when busy=0.
REQ-004 req_we  input  1  1 = store, 0 = load.
REQ-005 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-006 req_unsigned  input  1  load zero-extends when 1; sign-extends when 0; ignored for stores.
REQ-007 req_addr  input  32  byte address; bits [31:12] ignored.
REQ-008 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 busy  output  1  request in progress; high in every non-IDLE state.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  load result; valid while done=1.
REQ-012 misalign  output  1  one-cycle error pulse, coincident with done.
REQ-013 mem_addr  output  10  word address to data memory, bits [11:2] of latched address.
REQ-014 mem_din  output  32  write data to memory.
REQ-015 mem_we  output  1  memory write enable; memory writes on the rising clk edge.
REQ-016 mem_dout  input  32  memory read data, combinational from mem_addr.

Function
REQ-017 States: IDLE, RD, WR, DONE, ERR; encoding is free.
REQ-018 IDLE with req=1 at an edge: latch req_we, req_size, req_unsigned, req_addr and req_wdata, then choose the next state.
REQ-019 Next state from IDLE:
- ERR if misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
- WR for a aligned word store.
- RD otherwise.
REQ-020 req while busy=1 is ignored and never queued.
REQ-021 RD state:
- mem_we=0; mem_dout captured into a 32-bit buffer at the exiting edge.
- Loads go to DONE; byte/half stores go to WR.
REQ-022 WR state:
- mem_we=1.
- Word store: mem_din = wdata.
- Byte/half store: mem_din = buffer with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- Next state DONE.
REQ-023 Lane mapping is little-endian:
- Byte lane k occupies bits [8k+7:8k], with k = addr[1:0].
- Half at addr[1]=0 is [15:0]; at addr[1]=1 it is [31:16].
REQ-024 DONE and ERR each last exactly one cycle, assert done=1, then return to IDLE; a new request can be accepted at the edge that leaves DONE/ERR? No: it is sampled only in IDLE.
REQ-025 rdata in DONE for loads:
- The selected lane(s) of the buffer, extended to 32 bits by req_unsigned.
- Word loads return the buffer unchanged.
- rdata=0 in every other state and for stores.
REQ-026 ERR state:
- misalign=1; memory is never read for side effects and mem_we is never asserted for the request.
REQ-027 Latency from the accepting edge to the done pulse:
- Load: 2 cycles (RD, DONE).
- Word store: 2 cycles (WR, DONE).
- Byte/half store: 3 cycles (RD, WR, DONE).
- Error: 1 cycle.
REQ-028 mem_we is high only in WR; it is a registered-state decode with no dependence on the req inputs.
REQ-029 mem_addr holds the latched address bits [11:2] in all non-IDLE states, and 0 in IDLE.
REQ-030 mem_din is 0 outside WR.

Reset
REQ-031 rst=1 immediately (asynchronously) forces the following, independent of clk:
- state to IDLE;
- busy, done, misalign and mem_we to 0;
- rdata, mem_din, mem_addr and all latches to 0.
REQ-032 Reset asserted in RD or WR aborts the access; no memory write occurs at the next edge and no done pulse is produced.
REQ-033 After rst deasserts, the first request is accepted at the first rising edge with req=1.

Verification
REQ-034 Word store then byte loads:
- sw addr 0x100, data 0xDEADBEEF -> mem_we=1 for exactly 1 cycle, mem_addr=0x040, done 2 cycles after accept.
- lb 0x103 -> rdata 0xFFFFFFDE.
- lbu 0x101 -> rdata 0x000000BE.
REQ-035 Half store read-modify-write:
- sh 0x102, data 0x00001234 over word 0xDEADBEEF -> RD then WR, mem_din=0x1234BEEF, done 3 cycles after accept.
- lw 0x100 -> rdata 0x1234BEEF.
REQ-036 Byte store into lane 0:
- sb 0x100, data 0xAA -> memory word becomes 0x1234BEAA.
- lh 0x100 -> rdata 0xFFFFBEAA.
- lhu 0x100 -> rdata 0x0000BEAA.
REQ-037 Misaligned access:
- lh 0x101 -> ERR next cycle, done=1, misalign=1, rdata=0, mem_we never high.
- size=11 behaves identically.
REQ-038 Reset mid-operation:
- sb 0x104 issued, rst asserted while in WR before the edge -> mem_we drops at once, memory word unchanged, busy=0, no done pulse.
- The next lw 0x104 returns the original value.
REQ-039 Request while busy:
- req held high across a load -> only one access is performed and one done pulse produced.
- A second request is accepted only after the unit returns to IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with byte/half read-modify-write over a word memory
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  input  logic [31:0] mem_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state, state_nxt;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, buf_q;
  logic        mis_req;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_addr;

  // Only the low 4 KiB window is addressable.
  assign unused_addr = &{1'b0, req_addr[31:12]};

  always_comb begin
    mis_req = (req_size == 2'b11) ||
              (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (!req)                               state_nxt = S_IDLE;
        else if (mis_req)                       state_nxt = S_ERR;
        else if (req_we && req_size == 2'b10)   state_nxt = S_WR;
        else                                    state_nxt = S_RD;
      end
      S_RD:    state_nxt = we_q ? S_WR : S_DONE;
      S_WR:    state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 12'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr[11:0];
        wdata_q <= req_wdata;
      end
      if (state == S_RD)
        buf_q <= mem_dout;
    end
  end

  // Sub-word stores replace only the addressed lane(s) of the word read in RD.
  always_comb begin
    merged = buf_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = buf_q[7:0];
      2'd1:    byte_sel = buf_q[15:8];
      2'd2:    byte_sel = buf_q[23:16];
      default: byte_sel = buf_q[31:24];
    endcase
    half_sel = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
  end

  always_comb begin
    rdata = 32'd0;
    if (state == S_DONE && !we_q) begin
      case (size_q)
        2'b00:   rdata = {{24{~uns_q & byte_sel[7]}}, byte_sel};
        2'b01:   rdata = {{16{~uns_q & half_sel[15]}}, half_sel};
        default: rdata = buf_q;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE) || (state == S_ERR);
  assign misalign = (state == S_ERR);
  assign mem_we   = (state == S_WR);
  assign mem_addr = busy ? addr_q[11:2] : 10'd0;
  assign mem_din  = (state == S_WR) ? merged : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and randomized checks of mem_access_unit against a transaction model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        busy, done, misalign, mem_we;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .misalign(misalign),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  typedef struct packed {
    logic busy, done, mis, we;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] rdata;
  } exp_t;

  exp_t expq[$];
  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  bit pend_wr = 1'b0;
  logic [9:0]  pend_idx;
  logic [31:0] pend_val;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: the whole cycle-by-cycle outcome is decided at acceptance.
  task automatic model_accept(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] ad, input logic [31:0] wd);
    logic [9:0]  wi;
    logic [31:0] old, mask, sh, v, newv;
    bit err;
    wi  = ad[11:2];
    old = shadow[wi];
    err = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
    if (err) begin
      expq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, wi, 32'd0, 32'd0});
    end else if (we && sz == 2'b10) begin
      expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, wi, wd, 32'd0});
      expq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, wi, 32'd0, 32'd0});
    end else if (we) begin
      sh   = (sz == 2'b00) ? 32'(ad[1:0]) * 8 : 32'(ad[1]) * 16;
      mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      newv = (old & ~mask) | ((wd << sh) & mask);
      expq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, wi, 32'd0, 32'd0});
      expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, wi, newv, 32'd0});
      expq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, wi, 32'd0, 32'd0});
    end else begin
      if (sz == 2'b00) begin
        v = (old >> (32'(ad[1:0]) * 8)) & 32'hFF;
        if (!uns) v = (v ^ 32'h80) - 32'h80;
      end else if (sz == 2'b01) begin
        v = (old >> (32'(ad[1]) * 16)) & 32'hFFFF;
        if (!uns) v = (v ^ 32'h8000) - 32'h8000;
      end else begin
        v = old;
      end
      expq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, wi, 32'd0, 32'd0});
      expq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, wi, 32'd0, v});
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e, a;
      bit idle_now;
      idle_now = (expq.size() == 0);
      e = idle_now ? exp_t'(0) : expq.pop_front();
      a = {busy, done, misalign, mem_we, mem_addr, mem_din, rdata};
      chk("cycle", 96'(a), 96'(e));
      if (e.we) begin
        pend_wr  = 1'b1;
        pend_idx = e.addr;
        pend_val = e.din;
      end
      if (idle_now && req) model_accept(req_we, req_size, req_unsigned, req_addr, req_wdata);
    end
  end

  always @(posedge clk) begin
    if (pend_wr && !rst) shadow[pend_idx] = pend_val;
    pend_wr = 1'b0;
  end

  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] ad, input logic [31:0] wd, input bit hold,
                       output int lat, output logic [31:0] rd, output bit mis,
                       output int wcyc, output logic [31:0] wdin, output logic [9:0] wa);
    bit got;
    lat = 0; rd = 32'hX; mis = 1'b0; wcyc = 0; wdin = 32'd0; wa = 10'd0; got = 1'b0;
    @(posedge clk); #2;
    req = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = ad; req_wdata = wd;
    @(posedge clk); #2;
    if (!hold) req = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin wcyc++; wdin = mem_din; wa = mem_addr; end
      if (done) begin got = 1'b1; rd = rdata; mis = misalign; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL op_timeout: got no done within 10 cycles required done");
    end
    #1 req = 1'b0;
  endtask

  initial begin
    int lat, wc, cnt;
    logic [31:0] rd, wdin;
    logic [9:0] wa;
    bit mis;

    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'(i) * 32'h01010101 ^ 32'h5A3C96E1;
      shadow[i] = mem[i];
    end

    #3;
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done_mis_we", 96'({done, misalign, mem_we}), 96'd0);
    chk("rst_rdata_din_addr", 96'({rdata, mem_din, 22'd0, mem_addr}), 96'd0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #1 chk_en = 1'b1;

    do_op(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, lat, rd, mis, wc, wdin, wa);
    chk("sw_latency", 96'(lat), 96'd2);
    chk("sw_we_cycles", 96'(wc), 96'd1);
    chk("sw_mem_addr", 96'(wa), 96'h040);
    chk("sw_mem_word", 96'(mem[10'h040]), 96'hDEADBEEF);

    do_op(0, 2'b00, 0, 32'h103, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("lb_rdata", 96'(rd), 96'hFFFFFFDE);
    chk("lb_latency", 96'(lat), 96'd2);
    do_op(0, 2'b00, 1, 32'h101, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("lbu_rdata", 96'(rd), 96'h000000BE);

    do_op(1, 2'b01, 0, 32'h102, 32'h00001234, 0, lat, rd, mis, wc, wdin, wa);
    chk("sh_latency", 96'(lat), 96'd3);
    chk("sh_mem_din", 96'(wdin), 96'h1234BEEF);
    do_op(0, 2'b10, 0, 32'h100, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("lw_rdata", 96'(rd), 96'h1234BEEF);

    do_op(1, 2'b00, 0, 32'h100, 32'h000000AA, 0, lat, rd, mis, wc, wdin, wa);
    chk("sb_mem_word", 96'(mem[10'h040]), 96'h1234BEAA);
    chk("model_word", 96'(shadow[10'h040]), 96'h1234BEAA);
    do_op(0, 2'b01, 0, 32'h100, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("lh_rdata", 96'(rd), 96'hFFFFBEAA);
    do_op(0, 2'b01, 1, 32'h100, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("lhu_rdata", 96'(rd), 96'h0000BEAA);

    do_op(0, 2'b01, 0, 32'h101, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("mis_lh", 96'({lat, 31'd0, mis, rd}), 96'({32'd1, 31'd0, 1'b1, 32'd0}));
    chk("mis_lh_we", 96'(wc), 96'd0);
    do_op(1, 2'b11, 0, 32'h100, 32'hFFFFFFFF, 0, lat, rd, mis, wc, wdin, wa);
    chk("mis_rsv", 96'({lat, 31'd0, mis, rd}), 96'({32'd1, 31'd0, 1'b1, 32'd0}));
    chk("mis_rsv_we", 96'(wc), 96'd0);

    do_op(0, 2'b10, 0, 32'h100, 32'd0, 1, lat, rd, mis, wc, wdin, wa);
    chk("hold_rdata", 96'(rd), 96'h1234BEAA);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (done) cnt++; end
    chk("hold_extra_done", 96'(cnt), 96'd0);

    // Abort a sub-word store in WR with an asynchronous reset.
    do_op(1, 2'b10, 0, 32'h104, 32'hCAFEF00D, 0, lat, rd, mis, wc, wdin, wa);
    @(posedge clk); #2;
    req = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h104; req_wdata = 32'h55;
    @(posedge clk); #2 req = 1'b0;
    @(posedge clk); #2;
    chk("abort_pre_we", 96'(mem_we), 96'd1);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_outputs", 96'({busy, done, mem_we, misalign, mem_addr, mem_din}), 96'd0);
    expq.delete();
    pend_wr = 1'b0;
    cnt = 0;
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (done) cnt++; end
    chk("abort_no_done", 96'(cnt), 96'd0);
    chk("abort_mem_word", 96'(mem[10'h041]), 96'hCAFEF00D);
    #1 chk_en = 1'b1;
    do_op(0, 2'b10, 0, 32'h104, 32'd0, 0, lat, rd, mis, wc, wdin, wa);
    chk("abort_lw", 96'(rd), 96'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      int r;
      logic [1:0] sz;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_op(1'($urandom), sz, 1'($urandom),
            {20'($urandom), 12'h200 + 12'($urandom_range(0, 31))}, $urandom,
            1'($urandom), lat, rd, mis, wc, wdin, wa);
    end

    repeat (3) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== shadow[i]) cnt++;
    chk("mem_image_diffs", 96'(cnt), 96'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
